core_writeback_arb: RTL and testbench

Parametrised writeback arbiter that generalises core writeback to N_UNITS execution units sharing WR_PORTS register-file write ports.
- Each unit owns a one-entry holding register.
- Grants are round-robin, with a same-cycle write-after-write guard.
- Per-unit stall tells a unit it must hold its result.
- A pending-write mask feeds dispatch for RAW interlocks.
- Sits between the ALU/branch/ldst/mul units and core_regs.

---
 rtl/core_writeback_arb_pkg.sv | 25 ++
 rtl/core_writeback_arb_rr_pick.sv | 53 +++++
 rtl/core_writeback_arb.sv | 108 ++++++++++
 tb/tb_core_writeback_arb.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_writeback_arb_pkg.sv
// Shared micro-architecture types and helpers for the writeback path.
// Holds register-number/word types and the rotation helpers used by the arbiter.
package core_writeback_arb_pkg;

    localparam int UARCH_REG_BITS = 4;
    localparam int UARCH_W        = 32;

    typedef logic [UARCH_W-1:0]        word_t;
    typedef logic [UARCH_REG_BITS-1:0] reg_num_t;

    typedef struct packed {
        reg_num_t rd;
        word_t    data;
    } wb_line_t;

    // Single-step modular wrap; callers never exceed 2*n-1.
    function automatic int rr_wrap(input int v, input int n);
        return (v >= n) ? v - n : v;
    endfunction

    function automatic int idx_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/core_writeback_arb_rr_pick.sv
// Combinational round-robin picker: grants up to WR_PORTS holding
// registers in rotation order, skipping registers already granted this cycle.
module core_wb_rr_pick
    import core_writeback_arb_pkg::*;
#(
    parameter int N_UNITS  = 5,
    parameter int WR_PORTS = 2,
    parameter int REG_BITS = UARCH_REG_BITS,
    parameter int IW       = idx_bits(N_UNITS)
) (
    input  logic [N_UNITS-1:0]          i_hold_valid,
    input  logic [N_UNITS*REG_BITS-1:0] i_hold_reg,
    input  logic [IW-1:0]               i_rr_ptr,
    output logic [N_UNITS-1:0]          o_grant,
    output logic [WR_PORTS*IW-1:0]      o_port_idx,
    output logic [WR_PORTS-1:0]         o_port_vld,
    output logic [IW-1:0]               o_last
);

    logic [2**REG_BITS-1:0] w_used;
    logic [REG_BITS-1:0]    w_reg;
    int                     w_cnt;

    always_comb begin
        o_grant    = '0;
        o_port_idx = '0;
        o_port_vld = '0;
        o_last     = '0;
        w_used     = '0;
        w_reg      = '0;
        w_cnt      = 0;
        for (int k = 0; k < N_UNITS; k++) begin
            for (int i = 0; i < N_UNITS; i++) begin
                w_reg = i_hold_reg[i*REG_BITS +: REG_BITS];
                if (rr_wrap(int'(i_rr_ptr) + k, N_UNITS) == i &&
                    i_hold_valid[i] && !w_used[w_reg] &&
                    w_cnt < WR_PORTS) begin
                    o_grant[i]    = 1'b1;
                    o_last        = IW'(i);
                    w_used[w_reg] = 1'b1;
                    for (int p = 0; p < WR_PORTS; p++) begin
                        if (w_cnt == p) begin
                            o_port_idx[p*IW +: IW] = IW'(i);
                            o_port_vld[p]          = 1'b1;
                        end
                    end
                    w_cnt = w_cnt + 1;
                end
            end
        end
    end

endmodule

// File: rtl/core_writeback_arb.sv
// Writeback arbiter: one holding register per execution unit, round-robin
// grant onto WR_PORTS register-file write ports, plus a pending-write mask.
module core_writeback_arb
    import core_writeback_arb_pkg::*;
#(
    parameter int N_UNITS  = 5,
    parameter int WR_PORTS = 2,
    parameter int REG_BITS = UARCH_REG_BITS,
    parameter int W        = UARCH_W
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [N_UNITS-1:0]          req_valid,
    input  logic [N_UNITS*REG_BITS-1:0] req_reg,
    input  logic [N_UNITS*W-1:0]        req_data,
    output logic [N_UNITS-1:0]          wb_stall,
    output logic [WR_PORTS-1:0]         wr_en,
    output logic [WR_PORTS*REG_BITS-1:0] wr_reg,
    output logic [WR_PORTS*W-1:0]       wr_data,
    output logic [2**REG_BITS-1:0]      pending_mask
);

    localparam int IW = idx_bits(N_UNITS);

    if (N_UNITS < 1 || N_UNITS > 16 ||
        WR_PORTS < 1 || WR_PORTS > N_UNITS) begin : g_bad_cfg
        $error("core_writeback_arb: need 1<=WR_PORTS<=N_UNITS<=16");
    end

    logic [N_UNITS-1:0]          r_hold_valid;
    logic [N_UNITS*REG_BITS-1:0] r_hold_reg;
    logic [N_UNITS*W-1:0]        r_hold_data;
    logic [IW-1:0]               r_rr_ptr;

    logic [N_UNITS-1:0]     w_grant;
    logic [WR_PORTS*IW-1:0] w_port_idx;
    logic [WR_PORTS-1:0]    w_port_vld;
    logic [IW-1:0]          w_last;
    logic [IW-1:0]          w_next_ptr;

    core_wb_rr_pick #(
        .N_UNITS  (N_UNITS),
        .WR_PORTS (WR_PORTS),
        .REG_BITS (REG_BITS),
        .IW       (IW)
    ) u_pick (
        .i_hold_valid (r_hold_valid),
        .i_hold_reg   (r_hold_reg),
        .i_rr_ptr     (r_rr_ptr),
        .o_grant      (w_grant),
        .o_port_idx   (w_port_idx),
        .o_port_vld   (w_port_vld),
        .o_last       (w_last)
    );

    // Stall depends only on state and grant, never on req_valid.
    assign wb_stall   = r_hold_valid & ~w_grant;
    assign w_next_ptr = IW'(rr_wrap(int'(w_last) + 1, N_UNITS));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold_valid <= '0;
            r_hold_reg   <= '0;
            r_hold_data  <= '0;
            r_rr_ptr     <= '0;
        end else begin
            for (int i = 0; i < N_UNITS; i++) begin
                if (req_valid[i] && !wb_stall[i]) begin
                    r_hold_valid[i] <= 1'b1;
                    r_hold_reg[i*REG_BITS +: REG_BITS] <=
                        req_reg[i*REG_BITS +: REG_BITS];
                    r_hold_data[i*W +: W] <= req_data[i*W +: W];
                end else if (w_grant[i]) begin
                    r_hold_valid[i] <= 1'b0;
                end
            end
            if (|w_grant) begin
                r_rr_ptr <= w_next_ptr;
            end
        end
    end

    always_comb begin
        wr_en   = w_port_vld;
        wr_reg  = '0;
        wr_data = '0;
        for (int p = 0; p < WR_PORTS; p++) begin
            for (int i = 0; i < N_UNITS; i++) begin
                if (w_port_vld[p] &&
                    int'(w_port_idx[p*IW +: IW]) == i) begin
                    wr_reg[p*REG_BITS +: REG_BITS] =
                        r_hold_reg[i*REG_BITS +: REG_BITS];
                    wr_data[p*W +: W] = r_hold_data[i*W +: W];
                end
            end
        end
    end

    always_comb begin
        pending_mask = '0;
        for (int i = 0; i < N_UNITS; i++) begin
            if (r_hold_valid[i]) begin
                pending_mask[r_hold_reg[i*REG_BITS +: REG_BITS]] = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_core_writeback_arb.sv
// Directed bench for core_writeback_arb at N=5/P=2, N=8/P=3 and N=1/P=1.
module tb_core_writeback_arb;

    localparam int N  = 5;
    localparam int P  = 2;
    localparam int RB = 4;
    localparam int DW = 32;
    localparam int N8 = 8;
    localparam int P8 = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0]    req_valid = '0;
    logic [N*RB-1:0] req_reg   = '0;
    logic [N*DW-1:0] req_data  = '0;
    logic [N-1:0]    wb_stall;
    logic [P-1:0]    wr_en;
    logic [P*RB-1:0] wr_reg;
    logic [P*DW-1:0] wr_data;
    logic [15:0]     pending_mask;

    logic [N8-1:0]    e_valid = '0;
    logic [N8*RB-1:0] e_reg   = '0;
    logic [N8*DW-1:0] e_data  = '0;
    logic [N8-1:0]    e_stall;
    logic [P8-1:0]    e_wr_en;
    logic [P8*RB-1:0] e_wr_reg;
    logic [P8*DW-1:0] e_wr_data;
    logic [15:0]      e_pend;

    logic [0:0]    s_valid = '0;
    logic [RB-1:0] s_reg   = '0;
    logic [DW-1:0] s_data  = '0;
    logic [0:0]    s_stall;
    logic [0:0]    s_wr_en;
    logic [RB-1:0] s_wr_reg;
    logic [DW-1:0] s_wr_data;
    logic [15:0]   s_pend;

    core_writeback_arb #(.N_UNITS(N), .WR_PORTS(P), .REG_BITS(RB), .W(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_reg(req_reg), .req_data(req_data),
        .wb_stall(wb_stall), .wr_en(wr_en), .wr_reg(wr_reg),
        .wr_data(wr_data), .pending_mask(pending_mask)
    );

    core_writeback_arb #(.N_UNITS(N8), .WR_PORTS(P8), .REG_BITS(RB), .W(DW)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(e_valid), .req_reg(e_reg), .req_data(e_data),
        .wb_stall(e_stall), .wr_en(e_wr_en), .wr_reg(e_wr_reg),
        .wr_data(e_wr_data), .pending_mask(e_pend)
    );

    core_writeback_arb #(.N_UNITS(1), .WR_PORTS(1), .REG_BITS(RB), .W(DW)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(s_valid), .req_reg(s_reg), .req_data(s_data),
        .wb_stall(s_stall), .wr_en(s_wr_en), .wr_reg(s_wr_reg),
        .wr_data(s_wr_data), .pending_mask(s_pend)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [127:0] got,
                         input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_req(input int u, input logic [RB-1:0] r,
                           input logic [DW-1:0] d);
        req_valid[u]          = 1'b1;
        req_reg[u*RB +: RB]   = r;
        req_data[u*DW +: DW]  = d;
    endtask

    task automatic set8(input int u, input logic [RB-1:0] r,
                        input logic [DW-1:0] d);
        e_valid[u]         = 1'b1;
        e_reg[u*RB +: RB]  = r;
        e_data[u*DW +: DW] = d;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        req_valid = '0;
        e_valid   = '0;
        s_valid   = '0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        // Reset state
        @(negedge clk);
        check("rst_wr_en", wr_en, 0);
        check("rst_stall", wb_stall, 0);
        check("rst_pend", pending_mask, 0);
        check("rst_wr_data", wr_data, 0);
        check("rst8_wr_en", e_wr_en, 0);
        rst_n = 1'b1;

        // Single request, unit 2 -> r5
        do_reset();
        check("t1_idle_pend", pending_mask, 0);
        set_req(2, 4'd5, 32'hAA);
        @(negedge clk);
        req_valid = '0;
        check("t1_wr_en", wr_en, 2'b01);
        check("t1_wr_reg", wr_reg, 8'h05);
        check("t1_wr_data", wr_data, 64'hAA);
        check("t1_pend", pending_mask, 16'h0020);
        check("t1_stall", wb_stall, 0);
        @(negedge clk);
        check("t1_done_en", wr_en, 0);
        check("t1_done_pend", pending_mask, 0);

        // All five units, distinct registers
        do_reset();
        for (int i = 0; i < N; i++) set_req(i, RB'(i + 1), 32'h100 + i);
        @(negedge clk);
        req_valid = '0;
        check("t2c1_en", wr_en, 2'b11);
        check("t2c1_reg", wr_reg, 8'h21);
        check("t2c1_data", wr_data, {32'h101, 32'h100});
        check("t2c1_stall", wb_stall, 5'b11100);
        check("t2c1_pend", pending_mask, 16'h003E);
        @(negedge clk);
        check("t2c2_en", wr_en, 2'b11);
        check("t2c2_reg", wr_reg, 8'h43);
        check("t2c2_data", wr_data, {32'h103, 32'h102});
        check("t2c2_stall", wb_stall, 5'b10000);
        check("t2c2_pend", pending_mask, 16'h0038);
        @(negedge clk);
        check("t2c3_en", wr_en, 2'b01);
        check("t2c3_reg", wr_reg, 8'h05);
        check("t2c3_data", wr_data, 64'h104);
        check("t2c3_stall", wb_stall, 0);
        // Pointer wrapped to 0: unit 0 wins r9 over unit 4
        set_req(4, 4'd9, 32'h44);
        set_req(0, 4'd9, 32'h40);
        @(negedge clk);
        req_valid = '0;
        check("t2w_en", wr_en, 2'b01);
        check("t2w_reg", wr_reg, 8'h09);
        check("t2w_data", wr_data, 64'h40);
        check("t2w_stall", wb_stall, 5'b10000);
        check("t2w_pend", pending_mask, 16'h0200);
        @(negedge clk);
        check("t2w2_data", wr_data, 64'h44);
        check("t2w2_stall", wb_stall, 0);

        // WAW: units 0 and 3 both target r7
        do_reset();
        set_req(0, 4'd7, 32'h11);
        set_req(3, 4'd7, 32'h22);
        @(negedge clk);
        req_valid = '0;
        check("t3c1_en", wr_en, 2'b01);
        check("t3c1_reg", wr_reg, 8'h07);
        check("t3c1_data", wr_data, 64'h11);
        check("t3c1_stall", wb_stall, 5'b01000);
        check("t3c1_pend", pending_mask, 16'h0080);
        @(negedge clk);
        check("t3c2_en", wr_en, 2'b01);
        check("t3c2_data", wr_data, 64'h22);
        check("t3c2_stall", wb_stall, 0);
        @(negedge clk);
        check("t3c3_en", wr_en, 0);

        // Unit 1 streams r1..r4 back to back
        do_reset();
        for (int k = 0; k <= 4; k++) begin
            if (k > 0) begin
                check("t4_en", wr_en, 2'b01);
                check("t4_reg", wr_reg, 8'(k));
                check("t4_data", wr_data, 64'(32'h50 + k - 1));
                check("t4_stall", wb_stall, 0);
                check("t4_pend", pending_mask, 16'(1 << k));
            end
            if (k < 4) set_req(1, RB'(k + 1), 32'h50 + k);
            else req_valid = '0;
            @(negedge clk);
        end
        check("t4_idle", wr_en, 0);

        // Asynchronous reset with three holds pending
        do_reset();
        set_req(0, 4'd3, 32'h1);
        set_req(1, 4'd3, 32'h2);
        set_req(2, 4'd3, 32'h3);
        @(negedge clk);
        req_valid = '0;
        check("t5_pre_en", wr_en, 2'b01);
        check("t5_pre_stall", wb_stall, 5'b00110);
        check("t5_pre_pend", pending_mask, 16'h0008);
        #2 rst_n = 1'b0;
        #1;
        check("t5_rst_en", wr_en, 0);
        check("t5_rst_stall", wb_stall, 0);
        check("t5_rst_pend", pending_mask, 0);
        check("t5_rst_data", wr_data, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("t5_post_en", wr_en, 0);
        check("t5_post_pend", pending_mask, 0);
        @(negedge clk);
        check("t5_post2_en", wr_en, 0);

        // N=8, P=3: all units, distinct registers r8..r15
        do_reset();
        for (int i = 0; i < N8; i++) set8(i, RB'(i + 8), 32'h800 + i);
        @(negedge clk);
        e_valid = '0;
        check("t6c1_en", e_wr_en, 3'b111);
        check("t6c1_reg", e_wr_reg, 12'hA98);
        check("t6c1_data", e_wr_data, {32'h802, 32'h801, 32'h800});
        check("t6c1_stall", e_stall, 8'hF8);
        check("t6c1_pend", e_pend, 16'hFF00);
        @(negedge clk);
        check("t6c2_en", e_wr_en, 3'b111);
        check("t6c2_reg", e_wr_reg, 12'hDCB);
        check("t6c2_stall", e_stall, 8'hC0);
        @(negedge clk);
        check("t6c3_en", e_wr_en, 3'b011);
        check("t6c3_reg", e_wr_reg, 12'h0FE);
        check("t6c3_data", e_wr_data, {32'h0, 32'h807, 32'h806});
        check("t6c3_stall", e_stall, 0);
        set8(7, 4'd2, 32'h77);
        set8(0, 4'd2, 32'h70);
        @(negedge clk);
        e_valid = '0;
        check("t6w_en", e_wr_en, 3'b001);
        check("t6w_reg", e_wr_reg, 12'h002);
        check("t6w_data", e_wr_data, 96'h70);
        check("t6w_stall", e_stall, 8'h80);
        @(negedge clk);
        check("t6w2_data", e_wr_data, 96'h77);
        check("t6w2_stall", e_stall, 0);

        // N=1, P=1: back-to-back stream
        do_reset();
        s_valid = 1'b1;
        s_reg   = 4'd6;
        s_data  = 32'h61;
        @(negedge clk);
        s_reg  = 4'd7;
        s_data = 32'h62;
        check("t7c1_en", s_wr_en, 1'b1);
        check("t7c1_reg", s_wr_reg, 4'd6);
        check("t7c1_data", s_wr_data, 32'h61);
        check("t7c1_stall", s_stall, 0);
        @(negedge clk);
        s_valid = '0;
        check("t7c2_reg", s_wr_reg, 4'd7);
        check("t7c2_data", s_wr_data, 32'h62);
        check("t7c2_pend", s_pend, 16'h0080);
        @(negedge clk);
        check("t7c3_en", s_wr_en, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
